// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM encodings and iteration counter width.
package div_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage : div_pkg

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake plus operand and result buses of the divider.
interface seq_divider_if #(
  parameter int WIDTH = div_pkg::DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );

endinterface : seq_divider_if

// File: rtl/div_trial_sub.sv
// Combinational (WIDTH+1)-bit trial subtraction a - b done as a + ~b + 1;
// the carry out of the top bit is the "result is non-negative" flag.
module div_trial_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   diff_o,
  output logic             nonneg_o
);

  logic [WIDTH+1:0] sum;

  assign sum = {1'b0, a_i} + {1'b0, ~{1'b0, b_i}} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign {nonneg_o, diff_o} = sum;

endmodule : div_trial_sub

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, results
// held in output registers until the next accepted start.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   diff;
  logic             nonneg;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] q_d;
  logic             unused_diff_msb;

  // The shifted partial remainder keeps the bit pushed out of A, so a
  // remainder of 2^(WIDTH-1) or more still compares correctly against D.
  assign a_shift = {a_q, q_q[WIDTH-1]};

  div_trial_sub #(
    .WIDTH (WIDTH)
  ) u_trial_sub (
    .a_i      (a_shift),
    .b_i      (d_q),
    .diff_o   (diff),
    .nonneg_o (nonneg)
  );

  // A successful trial always leaves a difference below D, so its MSB is zero.
  assign a_d             = nonneg ? diff[WIDTH-1:0] : a_shift[WIDTH-1:0];
  assign q_d             = {q_q[WIDTH-2:0], nonneg};
  assign unused_diff_msb = diff[WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            d_q    <= bus.divisor;
            a_q    <= '0;
            q_q    <= bus.dividend;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (bus.divisor == '0) begin
              quot_q  <= '1;
              rem_q   <= bus.dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              dbz_q   <= 1'b0;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            quot_q  <= q_d;
            rem_q   <= a_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbz       = dbz_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider: latency, busy window, results,
// divide-by-zero, ignored starts and mid-run reset.
module tb_seq_divider;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request; the model result always comes from the first operands.
  task automatic run_div(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                         input int glitch_at, input int rst_at);
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    int          exp_lat;
    int          lat;
    int          busy_n;
    int          seen;
    bit          aborted;
    exp_q   = (dvs == 32'd0) ? 32'hFFFF_FFFF : dvd / dvs;
    exp_r   = (dvs == 32'd0) ? dvd : dvd % dvs;
    exp_lat = (dvs == 32'd0) ? 1 : 33;
    lat     = 0;
    busy_n  = 0;
    aborted = 1'b0;

    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk); #1;
    bus.start = 1'b0;

    for (int i = 1; i <= 40; i++) begin
      if (bus.busy) busy_n++;
      if (i == 5 && exp_lat > 5) begin
        check_val({tag, "_hold_q"}, bus.quotient, prev_q);
        check_val({tag, "_hold_r"}, bus.remainder, prev_r);
      end
      if (bus.done) begin
        lat = i;
        break;
      end
      if (i == glitch_at) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
      end
      if (i == rst_at) reset = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (reset) begin
        reset   = 1'b0;
        aborted = 1'b1;
        break;
      end
    end

    if (aborted) begin
      check_val({tag, "_rst_busy"}, 32'(bus.busy), 32'd0);
      check_val({tag, "_rst_done"}, 32'(bus.done), 32'd0);
      check_val({tag, "_rst_q"}, bus.quotient, 32'd0);
      check_val({tag, "_rst_r"}, bus.remainder, 32'd0);
      check_val({tag, "_rst_dbz"}, 32'(bus.dbz), 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (bus.done) seen++;
        @(posedge clk); #1;
      end
      check_val({tag, "_no_done"}, 32'(seen), 32'd0);
      prev_q = '0;
      prev_r = '0;
      $display("%s %0d/%0d aborted by reset", tag, dvd, dvs);
    end else begin
      check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check_val({tag, "_busy_n"}, 32'(busy_n), 32'(exp_lat));
      check_val({tag, "_q"}, bus.quotient, exp_q);
      check_val({tag, "_r"}, bus.remainder, exp_r);
      check_val({tag, "_dbz"}, 32'(bus.dbz), (dvs == 32'd0) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      check_val({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      check_val({tag, "_idle_done"}, 32'(bus.done), 32'd0);
      prev_q = exp_q;
      prev_r = exp_r;
      $display("%s %h/%h -> q=%h r=%h dbz=%0d lat=%0d", tag, dvd, dvs,
               bus.quotient, bus.remainder, bus.dbz, lat);
    end
  endtask

  initial begin
    logic [31:0] dvd;
    logic [31:0] dvs;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_q", bus.quotient, 32'd0);
    check_val("rst_r", bus.remainder, 32'd0);
    check_val("rst_dbz", 32'(bus.dbz), 32'd0);
    $display("reset state sampled");

    run_div("d100_7", 32'd100, 32'd7, 0, 0);
    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 0, 0);
    run_div("dmax_msb", 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    run_div("dbz", 32'd5, 32'd0, 0, 0);
    run_div("ign_start", 32'd3, 32'd10, 10, 0);
    run_div("rst_mid", 32'd1000, 32'd3, 0, 15);
    run_div("rerun", 32'd1000, 32'd3, 0, 0);

    for (int n = 0; n < 200; n++) begin
      dvd = $urandom;
      dvs = (n % 4 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (dvs == 32'd0) dvs = 32'd1;
      run_div("rnd", dvd, dvs, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_seq_divider
